// File: rtl/imm_ext_arbiter_if.sv
// Bundle between the two extension requesters (A: branch offset, B: ALU immediate)
// and the shared immediate extender.
interface imm_ext_arbiter_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16
);
    // Handshake: a requester raises req_x with imm_x/zext_x stable and keeps
    // req_x high until it sees the one-cycle done_x strobe, then drops it in the
    // following cycle. result is valid while done_x is high and holds until the
    // next completion. gnt_x marks the extension cycle of that requester.
    logic                 req_a;
    logic [IN_WIDTH-1:0]  imm_a;
    logic                 zext_a;
    logic                 req_b;
    logic [IN_WIDTH-1:0]  imm_b;
    logic                 zext_b;
    logic                 gnt_a;
    logic                 gnt_b;
    logic                 done_a;
    logic                 done_b;
    logic [OUT_WIDTH-1:0] result;
    logic                 busy;

    modport master (
        output req_a, imm_a, zext_a, req_b, imm_b, zext_b,
        input  gnt_a, gnt_b, done_a, done_b, result, busy
    );

    modport slave (
        input  req_a, imm_a, zext_a, req_b, imm_b, zext_b,
        output gnt_a, gnt_b, done_a, done_b, result, busy
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one IN_WIDTH->OUT_WIDTH sign/zero extender between
// two requesters; IDLE -> EXT -> RESP, chaining RESP -> EXT when the other side waits.
module imm_ext_arbiter #(
    parameter int IN_WIDTH   = 8,
    parameter int OUT_WIDTH  = 16,
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    imm_ext_arbiter_if.slave  bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXT  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state;
    logic                  owner;
    logic                  last_id;
    logic [IN_WIDTH-1:0]   lat_imm;
    logic                  lat_zext;
    logic                  gnt_a_q, gnt_b_q, done_a_q, done_b_q, busy_q;
    logic [OUT_WIDTH-1:0]  result_q;
    logic [OUT_WIDTH-1:0]  ext_val;
    logic                  grant_en;
    logic                  grant_id;

    assign ext_val = lat_zext ? {{(OUT_WIDTH-IN_WIDTH){1'b0}}, lat_imm}
                              : {{(OUT_WIDTH-IN_WIDTH){lat_imm[IN_WIDTH-1]}}, lat_imm};

    // In RESP the current owner's req is still high and must not win again.
    always_comb begin
        grant_en = 1'b0;
        grant_id = 1'b0;
        case (state)
            IDLE: begin
                grant_en = bus.req_a | bus.req_b;
                grant_id = (bus.req_a & bus.req_b) ? ~last_id : bus.req_b;
            end
            RESP: begin
                grant_en = owner ? bus.req_a : bus.req_b;
                grant_id = ~owner;
            end
            default: begin
                grant_en = 1'b0;
                grant_id = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last_id  <= ~FIRST_PRIO;
            lat_imm  <= '0;
            lat_zext <= 1'b0;
            result_q <= '0;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            done_a_q <= 1'b0;
            done_b_q <= 1'b0;
            if (state == EXT) begin
                result_q <= ext_val;
                done_a_q <= ~owner;
                done_b_q <= owner;
                state    <= RESP;
                busy_q   <= 1'b1;
            end else if (grant_en) begin
                owner    <= grant_id;
                last_id  <= grant_id;
                lat_imm  <= grant_id ? bus.imm_b : bus.imm_a;
                lat_zext <= grant_id ? bus.zext_b : bus.zext_a;
                gnt_a_q  <= ~grant_id;
                gnt_b_q  <= grant_id;
                state    <= EXT;
                busy_q   <= 1'b1;
            end else begin
                state    <= IDLE;
                busy_q   <= 1'b0;
            end
        end
    end

    assign bus.gnt_a  = gnt_a_q;
    assign bus.gnt_b  = gnt_b_q;
    assign bus.done_a = done_a_q;
    assign bus.done_b = done_b_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Scoreboarded bench for imm_ext_arbiter: directed latency/priority/reset cases
// plus randomized traffic against an arithmetic extension model.
module tb_imm_ext_arbiter;

    localparam int IW = 8;
    localparam int OW = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    imm_ext_arbiter_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    imm_ext_arbiter #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .FIRST_PRIO(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [OW-1:0] exp_a[$];
    logic [OW-1:0] exp_b[$];
    int order_q[$];

    // Value-level model: zero-extend is the plain number, sign-extend adds
    // 2^OW - 2^IW when the operand is negative.
    function automatic logic [OW-1:0] ext_model(input logic [IW-1:0] imm, input logic z);
        int v;
        v = int'(imm);
        if (!z && v >= (1 << (IW - 1))) v = v + (1 << OW) - (1 << IW);
        return OW'(v);
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_a = 1'b0; bus.imm_a = '0; bus.zext_a = 1'b0;
        bus.req_b = 1'b0; bus.imm_b = '0; bus.zext_b = 1'b0;
        exp_a.delete();
        exp_b.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue_a(input logic [IW-1:0] imm, input logic z);
        bus.req_a = 1'b1; bus.imm_a = imm; bus.zext_a = z;
        exp_a.push_back(ext_model(imm, z));
    endtask

    task automatic issue_b(input logic [IW-1:0] imm, input logic z);
        bus.req_b = 1'b1; bus.imm_b = imm; bus.zext_b = z;
        exp_b.push_back(ext_model(imm, z));
    endtask

    // Serve whichever requests are raised; each req drops the cycle after its done.
    task automatic serve(input bit need_a_in, input bit need_b_in);
        bit need_a, need_b, da, db;
        need_a = need_a_in;
        need_b = need_b_in;
        for (int g = 0; g < 30 && (need_a || need_b); g++) begin
            @(negedge clk);
            da = bus.done_a;
            db = bus.done_b;
            @(posedge clk);
            #1;
            if (da) begin bus.req_a = 1'b0; need_a = 1'b0; end
            if (db) begin bus.req_b = 1'b0; need_b = 1'b0; end
        end
        check_bit("serve_timeout", need_a | need_b, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_one_a(input logic [IW-1:0] imm, input logic z);
        issue_a(imm, z);
        serve(1'b1, 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic pg_a, pg_b;
        pg_a = 1'b0;
        pg_b = 1'b0;
        forever begin
            @(negedge clk);
            check_bit("gnt_exclusive", bus.gnt_a & bus.gnt_b, 1'b0);
            check_bit("done_exclusive", bus.done_a & bus.done_b, 1'b0);
            if (rst_n) begin
                if (pg_a) check_bit("done_a_after_gnt_a", bus.done_a, 1'b1);
                if (pg_b) check_bit("done_b_after_gnt_b", bus.done_b, 1'b1);
                if (bus.gnt_a | bus.gnt_b | bus.done_a | bus.done_b)
                    check_bit("busy_when_active", bus.busy, 1'b1);
                if (bus.done_a) begin
                    check_bit("done_a_expected", exp_a.size() != 0, 1'b1);
                    if (exp_a.size() != 0) check_val("result_a", bus.result, exp_a.pop_front());
                    order_q.push_back(0);
                end
                if (bus.done_b) begin
                    check_bit("done_b_expected", exp_b.size() != 0, 1'b1);
                    if (exp_b.size() != 0) check_val("result_b", bus.result, exp_b.pop_front());
                    order_q.push_back(1);
                end
            end
            pg_a = bus.gnt_a & rst_n;
            pg_b = bus.gnt_b & rst_n;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int na, nb, nd;
        bit da, db;
        bit [1:0] sel;

        do_reset();
        @(negedge clk);
        check_val("reset_result", bus.result, 16'h0000);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_gnt_a", bus.gnt_a, 1'b0);
        check_bit("reset_done_a", bus.done_a, 1'b0);

        // Single A request: latency gnt@1, done@2, idle@3.
        @(posedge clk); #1;
        issue_a(8'hF0, 1'b0);
        @(negedge clk);
        check_bit("c0_gnt_a", bus.gnt_a, 1'b0);
        @(negedge clk);
        check_bit("c1_gnt_a", bus.gnt_a, 1'b1);
        @(negedge clk);
        check_bit("c2_done_a", bus.done_a, 1'b1);
        check_val("c2_result", bus.result, 16'hFFF0);
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        @(negedge clk);
        check_bit("c3_busy", bus.busy, 1'b0);
        check_bit("c3_done_a", bus.done_a, 1'b0);

        // Single B request, then result holds across idle cycles.
        @(posedge clk); #1;
        issue_b(8'h0F, 1'b0);
        serve(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("result_hold", bus.result, 16'h000F);
            check_bit("idle_busy", bus.busy, 1'b0);
        end

        // Extension modes.
        @(posedge clk); #1;
        run_one_a(8'h80, 1'b1);
        run_one_a(8'h80, 1'b0);
        run_one_a(8'h7F, 1'b0);

        // Simultaneous requests after reset: A first, B chained without a bubble.
        do_reset();
        issue_a(8'hF0, 1'b0);
        issue_b(8'h0F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_bit("both_c1_gnt_a", bus.gnt_a, 1'b1);
        @(negedge clk);
        check_bit("both_c2_done_a", bus.done_a, 1'b1);
        check_val("both_c2_result", bus.result, 16'hFFF0);
        @(posedge clk); #1;
        bus.req_a = 1'b0;
        @(negedge clk);
        check_bit("both_c3_gnt_b", bus.gnt_b, 1'b1);
        check_bit("both_c3_busy", bus.busy, 1'b1);
        @(negedge clk);
        check_bit("both_c4_done_b", bus.done_b, 1'b1);
        check_val("both_c4_result", bus.result, 16'h000F);
        @(posedge clk); #1;
        bus.req_b = 1'b0;
        @(posedge clk); #1;

        // Back-to-back: both keep requesting for 8 operations; B was served last.
        order_q.delete();
        issue_a(IW'($urandom), 1'($urandom));
        issue_b(IW'($urandom), 1'($urandom));
        na = 1; nb = 1; nd = 0;
        for (int g = 0; g < 60 && nd < 8; g++) begin
            @(negedge clk);
            da = bus.done_a;
            db = bus.done_b;
            if (da || db) nd++;
            @(posedge clk); #1;
            if (da) begin
                if (na < 4) begin issue_a(IW'($urandom), 1'($urandom)); na++; end
                else bus.req_a = 1'b0;
            end
            if (db) begin
                if (nb < 4) begin issue_b(IW'($urandom), 1'($urandom)); nb++; end
                else bus.req_b = 1'b0;
            end
        end
        check_int("b2b_count", order_q.size(), 8);
        for (int i = 0; i < order_q.size(); i++) check_int("b2b_order", order_q[i], i % 2);
        @(posedge clk); #1;

        // Random traffic: A only, B only, or both.
        for (int i = 0; i < 12; i++) begin
            sel = 2'($urandom_range(1, 3));
            if (sel[0]) issue_a(IW'($urandom), 1'($urandom));
            if (sel[1]) issue_b(IW'($urandom), 1'($urandom));
            serve(sel[0], sel[1]);
        end

        // Reset during EXT: A's operation is abandoned, pending B served afterwards.
        run_one_a(8'h80, 1'b0);
        issue_a(8'hF0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_bit("rst_ext_gnt_a", bus.gnt_a, 1'b1);
        #1;
        rst_n = 1'b0;
        bus.req_a = 1'b0;
        exp_a.delete();
        issue_b(8'h0F, 1'b0);
        #1;
        check_val("rst_ext_result", bus.result, 16'h0000);
        check_bit("rst_ext_busy", bus.busy, 1'b0);
        check_bit("rst_ext_gnt_a_low", bus.gnt_a, 1'b0);
        check_bit("rst_ext_done_a", bus.done_a, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        serve(1'b0, 1'b1);
        check_val("rst_ext_b_result", bus.result, 16'h000F);

        repeat (3) @(posedge clk);
        check_int("exp_a_drained", exp_a.size(), 0);
        check_int("exp_b_drained", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
